// File: rtl/rc4_prga_decrypt_if.sv
// Control handshake plus the S, E and D memory buses of the RC4 PRGA decryptor.
interface rc4_prga_decrypt_if #(parameter int AW = 5);
    logic          start;
    logic          abort;
    logic [7:0]    s_addr;
    logic [7:0]    s_wdata;
    logic          s_wren;
    logic [7:0]    s_q;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_q;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_wdata;
    logic          d_wren;
    logic          busy;
    logic          done;
    logic          invalid;
    logic [AW:0]   char_count;

    modport master (
        input  start, abort, s_q, e_q,
        output s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren,
               busy, done, invalid, char_count
    );
    modport slave (
        output start, abort, s_q, e_q,
        input  s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren,
               busy, done, invalid, char_count
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA over a key-scheduled S RAM; XORs keystream with the encrypted ROM into D RAM,
// optionally stopping at the first byte outside the accepted character set.
module rc4_prga_decrypt #(
    parameter int         MSG_LEN  = 32,
    parameter int         AW       = $clog2(MSG_LEN),
    parameter int         RD_LAT   = 1,
    parameter bit         CHECK_EN = 1'b1,
    parameter logic [7:0] CH_LO    = 8'd97,
    parameter logic [7:0] CH_HI    = 8'd122
) (
    input  logic               clk,
    input  logic               reset,
    rc4_prga_decrypt_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J, WR_I, WR_J,
        RD_F, WT_F, CAP_F, WR_D, CHECK, INC, FIN
    } state_t;

    localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);
    localparam logic [AW-1:0] K_ONE  = AW'(1);
    localparam logic [AW:0]   C_ONE  = (AW + 1)'(1);
    localparam logic [2:0]    W_LAST = 3'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, eb_q, eb_d;
    logic [AW-1:0] k_q, k_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          invalid_q, invalid_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    f_addr, pt;
    logic          wt_last, ok;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        eb_d      = eb_q;
        wcnt_d    = wcnt_q;
        invalid_d = invalid_q;
        cnt_d     = cnt_q;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wren  = 1'b0;
        bus.e_addr  = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wren  = 1'b0;
        bus.done    = 1'b0;
        bus.busy    = (state_q != IDLE);
        f_addr  = si_q + sj_q;
        pt      = f_q ^ eb_q;
        wt_last = (wcnt_q == W_LAST);
        ok      = !CHECK_EN || (pt >= CH_LO && pt <= CH_HI) || pt == 8'd32;

        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RD_I; i_d = 8'd1; j_d = '0; k_d = '0;
                invalid_d = 1'b0; cnt_d = '0;
            end
            RD_I:  begin bus.s_addr = i_q; wcnt_d = '0; state_d = WT_I; end
            WT_I:  begin
                bus.s_addr = i_q;
                if (wt_last) state_d = CAP_I; else wcnt_d = wcnt_q + 3'd1;
            end
            // j advances with the value being captured so RD_J already sees the new j
            CAP_I: begin bus.s_addr = i_q; si_d = bus.s_q; j_d = j_q + bus.s_q; state_d = RD_J; end
            RD_J:  begin bus.s_addr = j_q; wcnt_d = '0; state_d = WT_J; end
            WT_J:  begin
                bus.s_addr = j_q;
                if (wt_last) state_d = CAP_J; else wcnt_d = wcnt_q + 3'd1;
            end
            CAP_J: begin bus.s_addr = j_q; sj_d = bus.s_q; state_d = WR_I; end
            WR_I:  begin bus.s_addr = i_q; bus.s_wdata = sj_q; bus.s_wren = 1'b1; state_d = WR_J; end
            WR_J:  begin bus.s_addr = j_q; bus.s_wdata = si_q; bus.s_wren = 1'b1; state_d = RD_F; end
            RD_F:  begin bus.s_addr = f_addr; bus.e_addr = k_q; wcnt_d = '0; state_d = WT_F; end
            WT_F:  begin
                bus.s_addr = f_addr; bus.e_addr = k_q;
                if (wt_last) state_d = CAP_F; else wcnt_d = wcnt_q + 3'd1;
            end
            CAP_F: begin
                bus.s_addr = f_addr; bus.e_addr = k_q;
                f_d = bus.s_q; eb_d = bus.e_q; state_d = WR_D;
            end
            WR_D:  begin bus.d_addr = k_q; bus.d_wdata = pt; bus.d_wren = 1'b1; state_d = CHECK; end
            CHECK: if (ok) begin cnt_d = cnt_q + C_ONE; state_d = INC; end
                   else begin invalid_d = 1'b1; state_d = FIN; end
            INC:   if (k_q == K_LAST) state_d = FIN;
                   else begin k_d = k_q + K_ONE; i_d = i_q + 8'd1; state_d = RD_I; end
            FIN:   begin bus.done = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase

        // abort wins over any bookkeeping of the current cycle; FIN always drains to IDLE
        if (bus.abort && state_q != IDLE && state_q != FIN) begin
            state_d   = FIN;
            invalid_d = invalid_q;
            cnt_d     = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            f_q       <= '0;
            eb_q      <= '0;
            wcnt_q    <= '0;
            invalid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            f_q       <= f_d;
            eb_q      <= eb_d;
            wcnt_q    <= wcnt_d;
            invalid_q <= invalid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.invalid    = invalid_q;
    assign bus.char_count = cnt_q;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench: three 4-byte instances (checked RD_LAT=1, unchecked RD_LAT=1, checked RD_LAT=3)
// each with its own S/D RAM model; expected values are hand-computed from S[x]=x.
module tb_rc4_prga_decrypt;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_init = 1'b1;
    logic start_v [3];
    logic abort_v [3];
    logic [7:0] emem [4];

    logic            busy_w [3];
    logic            done_w [3];
    logic            inv_w [3];
    logic            swren_w [3];
    logic            dwren_w [3];
    logic [7:0]      saddr_w [3];
    logic [AW:0]     cc_w [3];
    logic [3:0][7:0] dmem_w [3];

    logic [7:0] sa_tr [301];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int RL = (g == 2) ? 3 : 1;
        rc4_prga_decrypt_if #(.AW(AW)) bif ();
        logic [7:0]      smem [256];
        logic [3:0][7:0] dmem;
        logic [7:0]      sp [RL];
        logic [7:0]      ep [RL];

        rc4_prga_decrypt #(.MSG_LEN(4), .RD_LAT(RL), .CHECK_EN(g != 1)) dut (
            .clk(clk), .reset(reset), .bus(bif));

        assign bif.start  = start_v[g];
        assign bif.abort  = abort_v[g];
        assign bif.s_q    = sp[RL-1];
        assign bif.e_q    = ep[RL-1];
        assign busy_w[g]  = bif.busy;
        assign done_w[g]  = bif.done;
        assign inv_w[g]   = bif.invalid;
        assign swren_w[g] = bif.s_wren;
        assign dwren_w[g] = bif.d_wren;
        assign saddr_w[g] = bif.s_addr;
        assign cc_w[g]    = bif.char_count;
        assign dmem_w[g]  = dmem;

        always @(posedge clk) begin
            sp[0] <= smem[bif.s_addr];
            ep[0] <= emem[bif.e_addr];
            for (int p = 1; p < RL; p++) begin
                sp[p] <= sp[p-1];
                ep[p] <= ep[p-1];
            end
            if (mem_init) begin
                for (int a = 0; a < 256; a++) smem[a] <= 8'(a);
                dmem <= {4{8'hff}};
            end else begin
                if (bif.s_wren) smem[bif.s_addr] <= bif.s_wdata;
                if (bif.d_wren) dmem[bif.d_addr] <= bif.d_wdata;
            end
        end
    end

    task automatic reload();
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
    endtask

    task automatic set_e(input logic [7:0] e1);
        emem[0] = 8'h63; emem[1] = e1; emem[2] = 8'h64; emem[3] = 8'h69;
    endtask

    // start pulse, optional abort in cycle abort_at; n = edges from start sample to done
    task automatic run(input int inst, input int abort_at, output int n, output int sw, output int dw);
        n = 0; sw = 0; dw = 0;
        start_v[inst] = 1'b1;
        while (n < 300) begin
            @(posedge clk); n++; #1;
            start_v[inst] = 1'b0;
            abort_v[inst] = (n == abort_at);
            sa_tr[n] = saddr_w[inst];
            sw += int'(swren_w[inst]);
            dw += int'(dwren_w[inst]);
            if (done_w[inst]) break;
        end
        abort_v[inst] = 1'b0;
        tests++; if (done_w[inst] !== 1'b1) begin fails++; $display("FAIL run_done inst%0d: no done within %0d cycles", inst, n); end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            tests++; if ({busy_w[g], done_w[g], inv_w[g], swren_w[g], dwren_w[g]} !== 5'b0) begin fails++; $display("FAIL reset_flags inst%0d got %b want 00000", g, {busy_w[g], done_w[g], inv_w[g], swren_w[g], dwren_w[g]}); end
            tests++; if (saddr_w[g] !== 8'd0 || cc_w[g] !== 3'd0) begin fails++; $display("FAIL reset_vals inst%0d s_addr=%0d cc=%0d want 0 0", g, saddr_w[g], cc_w[g]); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [4];
        int n, sw, dw;
        exp[0] = 8'h61; exp[1] = 8'h62; exp[2] = 8'h63; exp[3] = 8'h64;
        set_e(8'h67); reload();
        run(0, 0, n, sw, dw);
        tests++; if (n !== 57) begin fails++; $display("FAIL basic_cycles got %0d want 57", n); end
        tests++; if (sa_tr[1] !== 8'd1) begin fails++; $display("FAIL basic_i0 got %0d want 1", sa_tr[1]); end
        tests++; if (sa_tr[9] !== 8'd2) begin fails++; $display("FAIL basic_faddr0 got %0d want 2", sa_tr[9]); end
        tests++; if (sa_tr[18] !== 8'd3) begin fails++; $display("FAIL basic_j1 got %0d want 3", sa_tr[18]); end
        tests++; if (sa_tr[23] !== 8'd5) begin fails++; $display("FAIL basic_faddr1 got %0d want 5", sa_tr[23]); end
        for (int a = 0; a < 4; a++) begin
            tests++; if (dmem_w[0][a] !== exp[a]) begin fails++; $display("FAIL basic_d%0d got %h want %h", a, dmem_w[0][a], exp[a]); end
        end
        tests++; if (inv_w[0] !== 1'b0 || cc_w[0] !== 3'd4) begin fails++; $display("FAIL basic_status inv=%b cc=%0d want 0 4", inv_w[0], cc_w[0]); end
        tests++; if (sw !== 8 || dw !== 4) begin fails++; $display("FAIL basic_writes s=%0d d=%0d want 8 4", sw, dw); end
    endtask

    task automatic test_invalid();
        int n, sw, dw;
        set_e(8'h05); reload();
        run(0, 0, n, sw, dw);
        tests++; if (n !== 28) begin fails++; $display("FAIL inv_cycles got %0d want 28", n); end
        tests++; if (dmem_w[0] !== 32'hffff_0061) begin fails++; $display("FAIL inv_dmem got %h want ffff0061", dmem_w[0]); end
        tests++; if (inv_w[0] !== 1'b1 || cc_w[0] !== 3'd1) begin fails++; $display("FAIL inv_status inv=%b cc=%0d want 1 1", inv_w[0], cc_w[0]); end
        tests++; if (dw !== 2) begin fails++; $display("FAIL inv_dwrites got %0d want 2", dw); end
        repeat (3) @(posedge clk); #1;
        tests++; if (inv_w[0] !== 1'b1 || cc_w[0] !== 3'd1 || busy_w[0] !== 1'b0) begin fails++; $display("FAIL inv_hold inv=%b cc=%0d busy=%b want 1 1 0", inv_w[0], cc_w[0], busy_w[0]); end
    endtask

    task automatic test_nocheck();
        int n, sw, dw;
        set_e(8'h05); reload();
        run(1, 0, n, sw, dw);
        tests++; if (n !== 57) begin fails++; $display("FAIL nochk_cycles got %0d want 57", n); end
        tests++; if (dmem_w[1] !== 32'h6463_0061) begin fails++; $display("FAIL nochk_dmem got %h want 64630061", dmem_w[1]); end
        tests++; if (inv_w[1] !== 1'b0 || cc_w[1] !== 3'd4) begin fails++; $display("FAIL nochk_status inv=%b cc=%0d want 0 4", inv_w[1], cc_w[1]); end
    endtask

    task automatic test_lat3();
        int n, sw, dw;
        set_e(8'h67); reload();
        run(2, 0, n, sw, dw);
        tests++; if (n !== 81) begin fails++; $display("FAIL lat3_cycles got %0d want 81", n); end
        tests++; if (sa_tr[21] !== 8'd2) begin fails++; $display("FAIL lat3_i1 got %0d want 2", sa_tr[21]); end
        tests++; if (dmem_w[2] !== 32'h6463_6261) begin fails++; $display("FAIL lat3_dmem got %h want 64636261", dmem_w[2]); end
        tests++; if (cc_w[2] !== 3'd4) begin fails++; $display("FAIL lat3_cc got %0d want 4", cc_w[2]); end
    endtask

    task automatic test_abort();
        int n, sw, dw;
        set_e(8'h67); reload();
        run(0, 33, n, sw, dw);
        tests++; if (sa_tr[33] !== 8'd5) begin fails++; $display("FAIL abort_wtj_addr got %0d want 5", sa_tr[33]); end
        tests++; if (n !== 34) begin fails++; $display("FAIL abort_cycles got %0d want 34", n); end
        tests++; if (sw !== 4 || dw !== 2) begin fails++; $display("FAIL abort_writes s=%0d d=%0d want 4 2", sw, dw); end
        tests++; if (cc_w[0] !== 3'd2 || inv_w[0] !== 1'b0) begin fails++; $display("FAIL abort_status cc=%0d inv=%b want 2 0", cc_w[0], inv_w[0]); end
        tests++; if (dmem_w[0] !== 32'hffff_6261) begin fails++; $display("FAIL abort_dmem got %h want ffff6261", dmem_w[0]); end
        reload();
        tests++; if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL abort_idle busy=%b want 0", busy_w[0]); end
        run(0, 0, n, sw, dw);
        tests++; if (sa_tr[1] !== 8'd1 || n !== 57) begin fails++; $display("FAIL abort_restart i=%0d cycles=%0d want 1 57", sa_tr[1], n); end
        tests++; if (dmem_w[0] !== 32'h6463_6261) begin fails++; $display("FAIL abort_restart_dmem got %h want 64636261", dmem_w[0]); end
    endtask

    task automatic test_reset_mid();
        reload();
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk); #1;
        tests++; if (swren_w[0] !== 1'b1 || saddr_w[0] !== 8'd1) begin fails++; $display("FAIL rstmid_wri wren=%b addr=%0d want 1 1", swren_w[0], saddr_w[0]); end
        reset = 1'b0; abort_v[0] = 1'b1;
        @(posedge clk); #1;
        tests++; if ({busy_w[0], done_w[0], swren_w[0], dwren_w[0], inv_w[0]} !== 5'b0 || saddr_w[0] !== 8'd0 || cc_w[0] !== 3'd0) begin fails++; $display("FAIL rstmid_outs busy=%b done=%b addr=%0d cc=%0d want all 0", busy_w[0], done_w[0], saddr_w[0], cc_w[0]); end
        abort_v[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_start_held();
        int n;
        reload();
        start_v[0] = 1'b1;
        n = 0;
        while (n < 300 && done_w[0] !== 1'b1) begin @(posedge clk); n++; #1; end
        tests++; if (n !== 57) begin fails++; $display("FAIL held_cycles got %0d want 57", n); end
        @(posedge clk); #1;
        tests++; if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL held_idle busy=%b want 0", busy_w[0]); end
        @(posedge clk); #1;
        tests++; if (busy_w[0] !== 1'b1) begin fails++; $display("FAIL held_restart busy=%b want 1", busy_w[0]); end
        start_v[0] = 1'b0;
        n = 0;
        while (n < 300 && done_w[0] !== 1'b1) begin @(posedge clk); n++; #1; end
        tests++; if (done_w[0] !== 1'b1) begin fails++; $display("FAIL held_second_done not seen within %0d cycles", n); end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin start_v[g] = 1'b0; abort_v[g] = 1'b0; end
        set_e(8'h67);
        repeat (3) @(posedge clk); #1;
        test_reset();
        reset = 1'b1;
        mem_init = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_invalid();
        test_nocheck();
        test_lat3();
        test_abort();
        test_reset_mid();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
